// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder/subtractor.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int NIBBLE_W = 4;

    function automatic int nib_count(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_csa.sv
// 4-bit carry-lookahead slice: all internal carries come from generate/propagate terms.
module csa (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    assign c[0] = cin_i;
    assign c[1] = g[0] | (p[0] & cin_i);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin_i);
    assign cout_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                  | (p[3] & p[2] & p[1] & g[0])
                  | (p[3] & p[2] & p[1] & p[0] & cin_i);

    assign sum_o = p ^ c;

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide add/sub built by cycling one 4-bit CLA slice over the operand nibbles,
// LSB first, with the inter-nibble carry held in a register.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    localparam int NIB   = nib_count(WIDTH);
    localparam int CNT_W = $clog2(NIB);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
        $error("nibble_serial_adder: WIDTH must be a multiple of 4 and at least 8");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             msb_a_q, msb_a_d;
    logic             msb_b_q, msb_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [NIBBLE_W-1:0] slice_sum;
    logic                slice_co;

    csa u_csa (
        .a_i    (a_q[NIBBLE_W-1:0]),
        .b_i    (b_q[NIBBLE_W-1:0]),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        msb_a_d = msb_a_q;
        msb_b_d = msb_b_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
                if (in_valid) begin
                    a_d     = a;
                    b_d     = op_sub ? ~b : b;
                    carry_d = op_sub;
                    msb_a_d = a[WIDTH-1];
                    msb_b_d = op_sub ? ~b[WIDTH-1] : b[WIDTH-1];
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                carry_d = slice_co;
                res_d   = {slice_sum, res_q[WIDTH-1:NIBBLE_W]};
                a_d     = a_q >> NIBBLE_W;
                b_d     = b_q >> NIBBLE_W;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            msb_a_q <= 1'b0;
            msb_b_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            msb_a_q <= msb_a_d;
            msb_b_q <= msb_b_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE) & ~rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = res_q;
    assign carry_out = carry_q;
    assign overflow  = (msb_a_q == msb_b_q) & (res_q[WIDTH-1] != msb_a_q);

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (WIDTH=16) with an arithmetic reference model.
module tb_nibble_serial_adder;

    localparam int W   = 16;
    localparam int NIB = W / 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;
    logic         busy;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        int           acc_cyc;
        bit           seen;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] dlv_q[$];
    int           cyc = 0;
    int           n_pass = 0;
    int           n_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: plain unsigned/signed arithmetic on the whole operands.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic sub);
        exp_t e;
        logic [W:0] t;
        int sx, sy, r;
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (sub) begin
            e.s = x - y;
            e.c = (x >= y);
            r   = sx - sy;
        end else begin
            t   = {1'b0, x} + {1'b0, y};
            e.s = t[W-1:0];
            e.c = t[W];
            r   = sx + sy;
        end
        e.v = (r > 32767) || (r < -32768);
        e.acc_cyc = 0;
        e.seen = 1'b0;
        return e;
    endfunction

    // Compare process: every negedge, outputs vs. model while out_valid.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    if (!exp_q[0].seen) begin
                        chk("latency", 32'(cyc - exp_q[0].acc_cyc), 32'(NIB + 1));
                        exp_q[0].seen = 1'b1;
                    end
                    chk("model_sum", 32'(sum), 32'(exp_q[0].s));
                    chk("model_carry", 32'(carry_out), 32'(exp_q[0].c));
                    chk("model_ovf", 32'(overflow), 32'(exp_q[0].v));
                    chk("in_ready_in_done", 32'(in_ready), 32'd0);
                    if (out_ready) begin
                        dlv_q.push_back(sum);
                        void'(exp_q.pop_front());
                    end
                end
            end else if (exp_q.size() != 0 && !exp_q[0].seen
                         && (cyc - exp_q[0].acc_cyc) > NIB + 1) begin
                chk("out_valid_late", 32'd0, 32'd1);
                exp_q[0].seen = 1'b1;
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e = model(a, b, op_sub);
                e.acc_cyc = cyc;
                exp_q.push_back(e);
            end
        end
    end

    task automatic wait_accept(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (!ok) chk({name, "_accept_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_result(input string name, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (out_valid) ok = 1'b1;
        end
        if (!ok) chk({name, "_result_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic sub, input logic [W-1:0] es, input logic ec, input logic ev);
        bit ok;
        in_valid = 1'b1; a = x; b = y; op_sub = sub;
        wait_accept(name);
        in_valid = 1'b0;
        wait_result(name, ok);
        if (ok) begin
            chk({name, "_sum"}, 32'(sum), 32'(es));
            chk({name, "_carry"}, 32'(carry_out), 32'(ec));
            chk({name, "_ovf"}, 32'(overflow), 32'(ev));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        bit ok;
        int t0, t1;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; op_sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_carry", 32'(carry_out), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        run_op("add_basic", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        run_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Backpressure: hold the result while in_valid pulses.
        out_ready = 1'b0;
        in_valid = 1'b1; a = 16'h1111; b = 16'h2222; op_sub = 1'b0;
        wait_accept("bp");
        in_valid = 1'b0;
        wait_result("bp", ok);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = ~in_valid; a = 16'hABCD; b = 16'h0101;
            @(negedge clk);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_sum", 32'(sum), 32'h3333);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Back-to-back with in_valid and out_ready held high.
        dlv_q.delete();
        in_valid = 1'b1; a = 16'h1234; b = 16'h1111; op_sub = 1'b0;
        wait_accept("b2b0");
        t0 = cyc;
        a = 16'h9000; b = 16'h1000; op_sub = 1'b1;
        wait_accept("b2b1");
        t1 = cyc;
        in_valid = 1'b0;
        chk("b2b_spacing", 32'(t1 - t0), 32'(NIB + 2));
        repeat (10) @(posedge clk);
        #1;
        chk("b2b_count", 32'(dlv_q.size()), 32'd2);
        if (dlv_q.size() == 2) begin
            chk("b2b_first", 32'(dlv_q[0]), 32'h2345);
            chk("b2b_second", 32'(dlv_q[1]), 32'h8000);
        end

        // Reset in the second RUN cycle aborts the operation.
        in_valid = 1'b1; a = 16'h4444; b = 16'h1111; op_sub = 1'b0;
        wait_accept("abort");
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        run_op("after_abort", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        chk("model_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide adder/subtractor that time-shares a single 4-bit carry-lookahead slice (`csa`) across the nibbles of a WIDTH-bit operand pair. It carries between nibbles through a registered carry. Operands are taken through a valid/ready input handshake and results are returned through a valid/ready output handshake. The block sits between the operand-issue logic and any consumer that needs wide add/sub without paying for a full-width carry-lookahead tree.

## Interface
- WIDTH, 16, operand/result width; multiple of 4, minimum 8
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair and op_sub present
- in_ready  output  1  block can accept an operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- op_sub  input  1  0: A+B, 1: A−B
- out_valid  output  1  result present
- out_ready  input  1  consumer takes the result
- sum  output  WIDTH  result, modulo 2^WIDTH
- carry_out  output  1  final carry; for subtract, 1 = no borrow (A ≥ B unsigned)
- overflow  output  1  two's-complement signed overflow
- busy  output  1  state ≠ IDLE

## Operation
- NIB = WIDTH/4. The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready, latch: A_reg = a; B_reg = op_sub ? ~b : b; carry_reg = op_sub; msb_a = a[WIDTH−1]; msb_b = B_reg MSB.
  - Clear the nibble counter to 0 and move to RUN.
- RUN, one nibble per cycle:
  - The slice sees A_reg[3:0], B_reg[3:0] and Cin = carry_reg.
  - On the clock edge, carry_reg takes the slice CarryOut.
  - The slice Sum shifts into the result register from the top, which gives LSB-first assembly.
  - A_reg and B_reg shift right by 4, and the counter increments.
  - When the counter reaches NIB−1, the next state is DONE.
- DONE:
  - out_valid = 1.
  - sum = result register; carry_out = carry_reg; overflow = (msb_a == msb_b) & (sum[WIDTH−1] ≠ msb_a).
  - All three hold stable until out_ready = 1, after which the next state is IDLE.
- in_ready is 0 in RUN and in DONE. in_valid is ignored there, so there is no overlap and no queueing.
- sum, carry_out and overflow are defined only while out_valid = 1:
  - In IDLE they retain the last delivered values.
  - In RUN they may change and are not checked.
- Counter width is clog2(NIB). It never wraps past NIB−1.

## Timing
- Reset, on the first edge with rst = 1:
  - State becomes IDLE.
  - out_valid, sum, carry_out, overflow, busy, carry_reg and the counter all become 0.
- in_ready is forced to 0 while rst = 1 and is 1 from the first cycle after reset deasserts.
- Latency: operation accepted at edge t, first out_valid cycle is t+NIB+1. For WIDTH=16 that is t+5.
- Throughput: one operation per NIB+2 cycles with out_ready held high.
- out_valid & out_ready at edge d: out_valid is 0 and in_ready is 1 in cycle d+1.
- Reset mid-operation in RUN or DONE aborts the operation. The next cycle is IDLE with all outputs 0, and no out_valid is produced for the aborted operation.
- rst takes priority over every handshake in the same cycle.
- in_valid and out_ready may change arbitrarily. Handshakes complete only on edges where both signals of the pair are 1.

## Structure
- Shared package `adder_pkg` holds:
  - the state enum (IDLE, RUN, DONE);
  - NIBBLE_W = 4;
  - a function computing NIB from WIDTH.
- Exactly one sub-module: one instance of the existing 4-bit carry-lookahead slice `csa`.
- Everything else (FSM, shift registers, carry register, counter, flag logic) lives in this module.
- An elaboration-time check rejects a WIDTH that is not a multiple of 4 or is below 8.

## Test plan
All scenarios use WIDTH=16.
- Add 0x1234 + 0x0FFF, op_sub=0, accepted at t → out_valid first at t+5 with sum=0x2233, carry_out=0, overflow=0.
- Add 0xFFFF + 0x0001 (carry ripples through all four nibble cycles) → sum=0x0000, carry_out=1, overflow=0. Add 0x7FFF + 0x0001 → sum=0x8000, carry_out=0, overflow=1.
- Subtract 0x0005 − 0x0007 → sum=0xFFFE, carry_out=0 (borrow), overflow=0. Subtract 0x8000 − 0x0001 → sum=0x7FFF, carry_out=1, overflow=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE while pulsing in_valid:
  - out_valid stays 1 and sum stays stable;
  - in_ready stays 0 and no new operation is accepted;
  - after out_ready=1, in_ready=1 in the next cycle.
- Back-to-back: hold in_valid=1 and out_ready=1 with two different operations → accepts are spaced exactly 6 cycles apart, both results are correct, and they return in order.
- Reset during RUN, second nibble cycle → next cycle has state IDLE, busy=0, out_valid=0, sum=0. No result appears for the aborted operation, and a fresh 0x0001 + 0x0001 returns 0x0002.
